// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage sequencer: walks every butterfly of every stage,
// presenting operand addresses and driving the twiddle-index counter controls.
module fft_stage_sequencer #(
  parameter int unsigned LOG2N        = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic             bfly_ready,
  output logic             bfly_valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [3:0]       stage_count_out,
  output logic             k_enable,
  output logic             k_clear,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned JW = LOG2N - 1;
  localparam logic [JW-1:0] J_LAST      = '1;
  localparam logic [3:0]    STAGE_LAST  = 4'(LOG2N - 1);
  localparam logic [3:0]    DRAIN_LOAD  = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_stage, w_stage_nxt;
  logic [JW-1:0] r_j, w_j_nxt;
  logic [3:0]    r_drain, w_drain_nxt;

  logic          w_issue;
  logic          w_hs;
  logic [AW-1:0] w_j_ext;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_k;
  logic [AW-1:0] w_grp;
  logic [AW-1:0] w_addr_a;

  // A handshake only counts when abort is not overriding the cycle
  assign w_issue = (r_state == S_ISSUE);
  assign w_hs    = w_issue & bfly_ready & ~abort;

  // Butterfly operand address generation from stage and butterfly index
  always_comb begin
    w_j_ext  = AW'(r_j);
    w_span   = ADDR_ONE << r_stage;
    w_k      = w_j_ext & (w_span - ADDR_ONE);
    w_grp    = (w_j_ext >> r_stage) << (r_stage + 4'd1);
    w_addr_a = w_grp | w_k;
  end

  // State, stage, butterfly and drain counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_j     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_j     <= w_j_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next-state and counter update logic; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_j_nxt     = r_j;
    w_drain_nxt = r_drain;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_CLEAR;
          w_stage_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_j_nxt     = '0;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_hs) begin
          w_j_nxt = r_j + JW'(1);
          if (r_j == J_LAST) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = DRAIN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == 4'd0) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_stage_nxt = r_stage + 4'd1;
            w_state_nxt = S_CLEAR;
          end
        end else begin
          w_drain_nxt = r_drain - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Outputs decoded from registered state; k_enable is the only ready-dependent one
  always_comb begin
    bfly_valid      = w_issue;
    addr_a          = w_issue ? w_addr_a : '0;
    addr_b          = w_issue ? (w_addr_a + w_span) : '0;
    stage_count_out = r_stage;
    k_enable        = w_hs;
    k_clear         = (r_state == S_CLEAR) | abort;
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_DONE);
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequences the radix-2 decimation-in-time FFT butterfly datapath across all stages. It does this by generating the stage number, the butterfly operand addresses and the control pulses for the twiddle-index counter. It sits between the top-level FFT control (start/done) and the butterfly unit plus sample-memory address ports. It owns the ordering of every butterfly in a 2^LOG2N-point transform.

## Interface
- LOG2N, default 8: log2 of the transform length (256 points, 8 stages, 128 butterflies per stage).
- DRAIN_CYCLES, default 4: idle cycles inserted after a stage's last butterfly so the butterfly pipeline writes back before the next stage reads (range 0..15).
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- bfly_ready  in  1  butterfly unit accepts the presented operand pair.
- bfly_valid  out  1  an operand pair is presented on addr_a/addr_b.
- addr_a  out  LOG2N  upper-wing sample address.
- addr_b  out  LOG2N  lower-wing sample address (addr_a + 2^stage).
- stage_count_out  out  4  current stage, 0..LOG2N-1.
- k_enable  out  1  advance the twiddle-index counter.
- k_clear  out  1  clear the twiddle-index counter to 0.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  one-cycle pulse when the final stage has drained.

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: all control outputs low. If start=1, go to CLEAR and load stage=0.
- CLEAR: lasts one cycle. k_clear=1 and j (butterfly counter, LOG2N-1 bits) is reset to 0. Then go to ISSUE.
- ISSUE: bfly_valid=1.
  - Addresses are combinational from stage s and j: k = j mod 2^s; group = j >> s; addr_a = (group << (s+1)) | k; addr_b = addr_a + 2^s.
  - On a handshake (bfly_valid & bfly_ready), k_enable=1 in the same cycle and j increments.
  - The external counter wraps at 2^s, so its index tracks k exactly.
  - When the handshake occurs with j = 2^(LOG2N-1)-1, go to DRAIN and load the drain counter.
- DRAIN: waits DRAIN_CYCLES cycles with bfly_valid=0. With DRAIN_CYCLES=0, it lasts exactly one cycle. On exit:
  - if s = LOG2N-1, go to DONE;
  - otherwise s increments and the block goes to CLEAR.
- DONE: done=1 for one cycle, then go to IDLE. stage_count_out keeps LOG2N-1 until the next start.
- Without a handshake, bfly_valid, addr_a and addr_b must hold stable. k_enable is never asserted without a handshake.
- abort has priority over every transition. The next state is IDLE, with k_clear=1 in the abort cycle. No done pulse is produced.
- start while busy is ignored. start and abort together in IDLE: abort wins and the block stays in IDLE.
- k_enable and k_clear are never high together.

## Timing
- Reset: state=IDLE. All outputs are 0: bfly_valid, addr_a, addr_b, stage_count_out, k_enable, k_clear, busy and done.
- start is sampled at edge T0. CLEAR is active in cycle T0+1 with busy=1 and k_clear=1. The first bfly_valid appears in T0+2.
- With bfly_ready tied high, each stage takes 1 (CLEAR) + 128 (ISSUE) + max(DRAIN_CYCLES,1) cycles. The default total is 8×133 = 1064 cycles from CLEAR entry to DONE, then done fires in the next cycle.
- All outputs are registered or decoded from registered state only; there are no combinational paths from bfly_ready to any output except k_enable.
- Reset mid-transform returns the block to the reset values immediately and asynchronously.

## Test plan
- Reset, then a start pulse with bfly_ready=1: k_clear in cycle 1; stage 0 pairs (0,1),(2,3)…(254,255); done occurs exactly 1064 cycles after CLEAR entry; busy falls with done.
- Stage 7 address check: the pairs are (j, j+128) for j=0..127. Stage 3, j=9 gives addr_a=17 and addr_b=25. For every handshake, the k_enable count per stage is 128.
- Random bfly_ready stalls (≈50% duty): addresses stay stable while stalled and no k_enable appears without ready. The sequence of pairs is identical to the no-stall run.
- abort asserted during stage 4 ISSUE: next cycle is IDLE, k_clear pulses once, no done, and a following start restarts from stage 0, pair (0,1).
- start pulsed during ISSUE and during DRAIN: ignored, with no change in the sequence or cycle count. With DRAIN_CYCLES=0, each stage takes 130 cycles.
- nrst asserted mid-stage 2 with bfly_valid high: all outputs are 0 asynchronously, and after release the block stays in IDLE until start.
